// File: rtl/ce_cei_ctl_pkg.sv
// Shared definitions for the core-side custom-engine interface: op field
// layout, ISA opcode constants, halt-bus width and controller state encoding.
package ce_cei_ctl_pkg;

  localparam int unsigned CEI_OP_W       = 12;
  localparam int unsigned CEI_OP_MAJ_MSB = 11;
  localparam int unsigned CEI_OP_MAJ_LSB = 6;
  localparam int unsigned CEI_OP_FN_MSB  = 5;
  localparam int unsigned CEI_OP_FN_LSB  = 0;

  localparam logic [5:0] M32_MAJ_SPECIAL  = 6'h00;
  localparam logic [5:0] M32_MAJ_SPECIAL2 = 6'h1c;
  localparam logic [5:0] M32_MAJ_CE       = 6'h1f;
  localparam logic [5:0] M16_MAJ_CE       = 6'h3e;

  // M32 SPECIAL/SLL with all-zero fields: never decoded as a CE op
  localparam logic [CEI_OP_W-1:0] CEI_NOP_OP = 12'h000;

  localparam int unsigned CEI_HALT_DRV_COUNT = 4;
  localparam int unsigned CEI_HCNT_W         = 8;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_CEHALT = 2'b01,
    ST_HOLD   = 2'b10
  } cei_state_t;

  function automatic logic [CEI_OP_W-1:0] cei_slot_op(
    input logic                valid,
    input logic [CEI_OP_W-1:0] op,
    input logic [CEI_OP_W-1:0] nop
  );
    return valid ? op : nop;
  endfunction

endpackage

// File: rtl/ce_cei_haltmon.sv
// CE halt-bus monitor: replicated-halt reduction, disagreement flag, stall
// state tracking and a saturating count of cycles spent halted by the CE.
module ce_cei_haltmon
  import ce_cei_ctl_pkg::*;
#(
  parameter int unsigned HALT_DRV_COUNT = CEI_HALT_DRV_COUNT,
  parameter int unsigned HCNT_W         = CEI_HCNT_W
) (
  input  logic                      CLK,
  input  logic                      RESET_D1_R_N,
  input  logic [HALT_DRV_COUNT-1:0] HALT_C,
  input  logic                      PIPE_HOLD,
  input  logic                      XCPN,
  output logic                      HALT_ANY,
  output logic                      HALT_MISMATCH,
  output logic [HCNT_W-1:0]         HALT_CNT,
  output cei_state_t                STATE
);

  logic halt_all;

  assign HALT_ANY      = |HALT_C;
  assign halt_all      = &HALT_C;
  assign HALT_MISMATCH = HALT_ANY & ~halt_all;

  always_ff @(posedge CLK or negedge RESET_D1_R_N) begin
    if (!RESET_D1_R_N) begin
      STATE    <= ST_RUN;
      HALT_CNT <= '0;
    end else begin
      if (STATE == ST_CEHALT && HALT_CNT != '1)
        HALT_CNT <= HALT_CNT + 1'b1;

      // Exception flush overrides every transition; halt outranks hold
      if (XCPN) begin
        STATE <= ST_RUN;
      end else begin
        unique case (STATE)
          ST_RUN: begin
            if (HALT_ANY)       STATE <= ST_CEHALT;
            else if (PIPE_HOLD) STATE <= ST_HOLD;
          end
          ST_CEHALT: begin
            if (!HALT_ANY)      STATE <= PIPE_HOLD ? ST_HOLD : ST_RUN;
          end
          ST_HOLD: begin
            if (HALT_ANY)       STATE <= ST_CEHALT;
            else if (!PIPE_HOLD) STATE <= ST_RUN;
          end
          default:              STATE <= ST_RUN;
        endcase
      end
    end
  end

endmodule

// File: rtl/ce_cei_ctl.sv
// Core-side CE interface initiator: S-stage op and E-stage operand registers,
// M-stage result capture, and stall/hold/kill signalling to and from the CE.
module ce_cei_ctl
  import ce_cei_ctl_pkg::*;
#(
  parameter int unsigned HALT_DRV_COUNT = CEI_HALT_DRV_COUNT,
  parameter logic [11:0] NOP_OP         = CEI_NOP_OP,
  parameter int unsigned HCNT_W         = CEI_HCNT_W
) (
  input  logic                      CLK,
  input  logic                      RESET_D1_R_N,
  input  logic [11:0]               DEC_OP_S,
  input  logic                      DEC_INSTM32_S_N,
  input  logic                      DEC_VALID_S,
  input  logic [31:0]               RF_AOP_D,
  input  logic [31:0]               RF_BOP_D,
  input  logic                      PIPE_HOLD,
  input  logic                      XCPN_M,
  input  logic [31:0]               CE_RES_E,
  input  logic                      CE_SEL_E_R,
  input  logic [HALT_DRV_COUNT-1:0] CE_HALT_E_R_C,
  output logic [11:0]               CEI_OP_S_R,
  output logic                      CEI_INSTM32_S_R_N,
  output logic [31:0]               CEI_AOP_E_R,
  output logic [31:0]               CEI_BOP_E_R,
  output logic                      CEI_CEHOLD,
  output logic                      CEI_XCPN_M,
  output logic [31:0]               CEI_RES_M_R,
  output logic                      CEI_RES_VLD_M_R,
  output logic                      CEI_STALL,
  output logic                      CEI_HALT_MISMATCH,
  output logic [HCNT_W-1:0]         CEI_HALT_CNT
);

  logic       halt_any;
  logic       advance;
  cei_state_t fsm_state;

  ce_cei_haltmon #(
    .HALT_DRV_COUNT(HALT_DRV_COUNT),
    .HCNT_W        (HCNT_W)
  ) u_haltmon (
    .CLK          (CLK),
    .RESET_D1_R_N (RESET_D1_R_N),
    .HALT_C       (CE_HALT_E_R_C),
    .PIPE_HOLD    (PIPE_HOLD),
    .XCPN         (XCPN_M),
    .HALT_ANY     (halt_any),
    .HALT_MISMATCH(CEI_HALT_MISMATCH),
    .HALT_CNT     (CEI_HALT_CNT),
    .STATE        (fsm_state)
  );

  // The CE folds its own halt into its hold, so only the non-CE stall goes out
  assign CEI_CEHOLD = PIPE_HOLD;
  assign CEI_XCPN_M = XCPN_M;
  assign CEI_STALL  = PIPE_HOLD | halt_any;
  assign advance    = ~CEI_STALL;

  always_ff @(posedge CLK or negedge RESET_D1_R_N) begin
    if (!RESET_D1_R_N) begin
      CEI_OP_S_R        <= NOP_OP;
      CEI_INSTM32_S_R_N <= 1'b0;
      CEI_AOP_E_R       <= '0;
      CEI_BOP_E_R       <= '0;
      CEI_RES_M_R       <= '0;
      CEI_RES_VLD_M_R   <= 1'b0;
    end else if (XCPN_M) begin
      // Flush wins over stall; the captured result data is left in place
      CEI_OP_S_R        <= NOP_OP;
      CEI_INSTM32_S_R_N <= 1'b0;
      CEI_AOP_E_R       <= '0;
      CEI_BOP_E_R       <= '0;
      CEI_RES_VLD_M_R   <= 1'b0;
    end else if (advance) begin
      CEI_OP_S_R        <= cei_slot_op(DEC_VALID_S, DEC_OP_S, NOP_OP);
      CEI_INSTM32_S_R_N <= DEC_VALID_S & DEC_INSTM32_S_N;
      CEI_AOP_E_R       <= RF_AOP_D;
      CEI_BOP_E_R       <= RF_BOP_D;
      CEI_RES_VLD_M_R   <= CE_SEL_E_R;
      if (CE_SEL_E_R)
        CEI_RES_M_R     <= CE_RES_E;
    end
  end

endmodule

// File: tb/tb_ce_cei_ctl.sv
// Directed bench for ce_cei_ctl: op/operand pipelining, result capture,
// CE halt and pipe hold sequencing, exception flush and counter saturation.
module tb_ce_cei_ctl;

  logic        CLK;
  logic        RESET_D1_R_N;
  logic [11:0] DEC_OP_S;
  logic        DEC_INSTM32_S_N;
  logic        DEC_VALID_S;
  logic [31:0] RF_AOP_D;
  logic [31:0] RF_BOP_D;
  logic        PIPE_HOLD;
  logic        XCPN_M;
  logic [31:0] CE_RES_E;
  logic        CE_SEL_E_R;
  logic [3:0]  CE_HALT_E_R_C;
  logic [11:0] CEI_OP_S_R;
  logic        CEI_INSTM32_S_R_N;
  logic [31:0] CEI_AOP_E_R;
  logic [31:0] CEI_BOP_E_R;
  logic        CEI_CEHOLD;
  logic        CEI_XCPN_M;
  logic [31:0] CEI_RES_M_R;
  logic        CEI_RES_VLD_M_R;
  logic        CEI_STALL;
  logic        CEI_HALT_MISMATCH;
  logic [7:0]  CEI_HALT_CNT;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned n_fail   = 0;

  ce_cei_ctl #(
    .HALT_DRV_COUNT(4),
    .NOP_OP        (12'h000),
    .HCNT_W        (8)
  ) dut (
    .CLK              (CLK),
    .RESET_D1_R_N     (RESET_D1_R_N),
    .DEC_OP_S         (DEC_OP_S),
    .DEC_INSTM32_S_N  (DEC_INSTM32_S_N),
    .DEC_VALID_S      (DEC_VALID_S),
    .RF_AOP_D         (RF_AOP_D),
    .RF_BOP_D         (RF_BOP_D),
    .PIPE_HOLD        (PIPE_HOLD),
    .XCPN_M           (XCPN_M),
    .CE_RES_E         (CE_RES_E),
    .CE_SEL_E_R       (CE_SEL_E_R),
    .CE_HALT_E_R_C    (CE_HALT_E_R_C),
    .CEI_OP_S_R       (CEI_OP_S_R),
    .CEI_INSTM32_S_R_N(CEI_INSTM32_S_R_N),
    .CEI_AOP_E_R      (CEI_AOP_E_R),
    .CEI_BOP_E_R      (CEI_BOP_E_R),
    .CEI_CEHOLD       (CEI_CEHOLD),
    .CEI_XCPN_M       (CEI_XCPN_M),
    .CEI_RES_M_R      (CEI_RES_M_R),
    .CEI_RES_VLD_M_R  (CEI_RES_VLD_M_R),
    .CEI_STALL        (CEI_STALL),
    .CEI_HALT_MISMATCH(CEI_HALT_MISMATCH),
    .CEI_HALT_CNT     (CEI_HALT_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RESET_D1_R_N    = 1'b0;
    DEC_OP_S        = '0;
    DEC_INSTM32_S_N = 1'b0;
    DEC_VALID_S     = 1'b0;
    RF_AOP_D        = '0;
    RF_BOP_D        = '0;
    PIPE_HOLD       = 1'b0;
    XCPN_M          = 1'b0;
    CE_RES_E        = '0;
    CE_SEL_E_R      = 1'b0;
    CE_HALT_E_R_C   = '0;
    step();
    step();
    chk("rst_op",    32'(CEI_OP_S_R), 32'h000);
    chk("rst_aop",   CEI_AOP_E_R, 32'h0);
    chk("rst_vld",   32'(CEI_RES_VLD_M_R), 32'h0);
    chk("rst_cnt",   32'(CEI_HALT_CNT), 32'h0);
    chk("rst_stall", 32'(CEI_STALL), 32'h0);
    chk("rst_state", 32'(dut.fsm_state), 32'h0);

    // Decode MFHI, operands follow one cycle later
    RESET_D1_R_N    = 1'b1;
    DEC_VALID_S     = 1'b1;
    DEC_OP_S        = 12'h010;
    DEC_INSTM32_S_N = 1'b1;
    step();
    chk("s_op",   32'(CEI_OP_S_R), 32'h010);
    chk("s_m16",  32'(CEI_INSTM32_S_R_N), 32'h1);
    chk("e_aop0", CEI_AOP_E_R, 32'h0);
    DEC_VALID_S = 1'b0;
    RF_AOP_D    = 32'h1234_5678;
    RF_BOP_D    = 32'hCAFE_F00D;
    step();
    chk("e_aop",    CEI_AOP_E_R, 32'h1234_5678);
    chk("e_bop",    CEI_BOP_E_R, 32'hCAFE_F00D);
    chk("s_nop",    32'(CEI_OP_S_R), 32'h000);
    chk("s_m16_mt", 32'(CEI_INSTM32_S_R_N), 32'h0);

    // Result capture then release
    CE_SEL_E_R = 1'b1;
    CE_RES_E   = 32'hDEAD_BEEF;
    step();
    chk("res",     CEI_RES_M_R, 32'hDEAD_BEEF);
    chk("res_vld", 32'(CEI_RES_VLD_M_R), 32'h1);
    CE_SEL_E_R = 1'b0;
    CE_RES_E   = 32'h1111_1111;
    step();
    chk("res_hold",  CEI_RES_M_R, 32'hDEAD_BEEF);
    chk("res_vld_0", 32'(CEI_RES_VLD_M_R), 32'h0);

    // Three cycles of full CE halt
    DEC_VALID_S     = 1'b1;
    DEC_OP_S        = 12'h3A5;
    DEC_INSTM32_S_N = 1'b0;
    RF_AOP_D        = 32'hAAAA_AAAA;
    step();
    DEC_OP_S      = 12'h0FF;
    RF_AOP_D      = 32'h5555_5555;
    CE_HALT_E_R_C = 4'hF;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("halt_stall", 32'(CEI_STALL), 32'h1);
      chk("halt_nomm",  32'(CEI_HALT_MISMATCH), 32'h0);
      step();
    end
    chk("halt_op_hold",  32'(CEI_OP_S_R), 32'h3A5);
    chk("halt_aop_hold", CEI_AOP_E_R, 32'hAAAA_AAAA);
    chk("halt_state",    32'(dut.fsm_state), 32'h1);
    CE_HALT_E_R_C = 4'h0;
    #1;
    chk("unhalt_stall", 32'(CEI_STALL), 32'h0);
    step();
    chk("halt_cnt3",  32'(CEI_HALT_CNT), 32'd3);
    chk("halt_run",   32'(dut.fsm_state), 32'h0);
    chk("unhalt_op",  32'(CEI_OP_S_R), 32'h0FF);
    chk("unhalt_aop", CEI_AOP_E_R, 32'h5555_5555);

    // Disagreeing replicas, then halt+hold, then hold alone
    CE_HALT_E_R_C = 4'b0101;
    #1;
    chk("mm_stall", 32'(CEI_STALL), 32'h1);
    chk("mm_flag",  32'(CEI_HALT_MISMATCH), 32'h1);
    step();
    chk("mm_state", 32'(dut.fsm_state), 32'h1);
    PIPE_HOLD = 1'b1;
    #1;
    chk("cehold_1", 32'(CEI_CEHOLD), 32'h1);
    step();
    chk("hh_state", 32'(dut.fsm_state), 32'h1);
    CE_HALT_E_R_C = 4'h0;
    #1;
    chk("hold_stall", 32'(CEI_STALL), 32'h1);
    chk("hold_nomm",  32'(CEI_HALT_MISMATCH), 32'h0);
    step();
    chk("hold_state", 32'(dut.fsm_state), 32'h2);
    PIPE_HOLD = 1'b0;
    #1;
    chk("cehold_0", 32'(CEI_CEHOLD), 32'h0);
    step();
    chk("hold_run", 32'(dut.fsm_state), 32'h0);
    chk("cnt5",     32'(CEI_HALT_CNT), 32'd5);

    // Exception during a halt flushes S/E and the valid bit
    DEC_OP_S   = 12'h123;
    CE_SEL_E_R = 1'b1;
    CE_RES_E   = 32'h0BAD_F00D;
    step();
    chk("pre_x_vld", 32'(CEI_RES_VLD_M_R), 32'h1);
    CE_SEL_E_R    = 1'b0;
    CE_HALT_E_R_C = 4'hF;
    step();
    XCPN_M = 1'b1;
    #1;
    chk("xcpn_pass", 32'(CEI_XCPN_M), 32'h1);
    step();
    chk("x_op",    32'(CEI_OP_S_R), 32'h000);
    chk("x_aop",   CEI_AOP_E_R, 32'h0);
    chk("x_vld",   32'(CEI_RES_VLD_M_R), 32'h0);
    chk("x_res",   CEI_RES_M_R, 32'h0BAD_F00D);
    chk("x_state", 32'(dut.fsm_state), 32'h0);
    chk("x_cnt",   32'(CEI_HALT_CNT), 32'd6);
    XCPN_M = 1'b0;
    for (int i = 0; i < 300; i++) step();
    chk("cnt_sat",   32'(CEI_HALT_CNT), 32'hFF);
    chk("sat_state", 32'(dut.fsm_state), 32'h1);

    // Asynchronous reset in the middle of a stall
    PIPE_HOLD = 1'b1;
    step();
    RESET_D1_R_N = 1'b0;
    #1;
    chk("mr_cnt",   32'(CEI_HALT_CNT), 32'h0);
    chk("mr_state", 32'(dut.fsm_state), 32'h0);
    chk("mr_op",    32'(CEI_OP_S_R), 32'h000);
    CE_HALT_E_R_C = 4'h0;
    PIPE_HOLD     = 1'b0;
    #1;
    chk("mr_stall", 32'(CEI_STALL), 32'h0);
    RESET_D1_R_N = 1'b1;
    step();
    chk("mr_run", 32'(dut.fsm_state), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ce_cei_ctl.md
Name: ce_cei_ctl

Overview:
- Core-side initiator of the custom-engine (CE) interface.
- Registers decoded instruction fields into the S-stage CEI op bus and captures register-file operands into the E-stage operand buses.
- Drives CE hold and exception kill; consumes CE_RES_E, CE_SEL_E_R and the replicated halt bus.
- Returns a registered M-stage result and a pipeline stall to the core.

Parameters:
HALT_DRV_COUNT, 4, replication width of the CE halt bus (matches `HALT_DRV_COUNT in core_symbols).
NOP_OP, 12'h000, opcode injected on CEI_OP_S_R when the S slot is empty (M32 SPECIAL/SLL; not a CE op).
HCNT_W, 8, width of the saturating halt-cycle statistics counter.

Ports:
CLK  in  1  core clock
RESET_D1_R_N  in  1  asynchronous active-low reset
DEC_OP_S  in  12  {major opcode[5:0], function[5:0]} from decode; M16 ops packed per CE convention
DEC_INSTM32_S_N  in  1  0 = M32 instruction, 1 = M16
DEC_VALID_S  in  1  instruction present in decode
RF_AOP_D  in  32  A operand from register-file read
RF_BOP_D  in  32  B operand from register-file read
PIPE_HOLD  in  1  non-CE pipeline stall (cache miss etc.)
XCPN_M  in  1  exception taken in M stage
CE_RES_E  in  32  CE result, E stage
CE_SEL_E_R  in  1  CE owns the E-stage result
CE_HALT_E_R_C  in  HALT_DRV_COUNT  CE halt request, replicated
CEI_OP_S_R  out  12  registered S-stage op to CE
CEI_INSTM32_S_R_N  out  1  registered ISA-mode flag
CEI_AOP_E_R  out  32  E-stage A operand
CEI_BOP_E_R  out  32  E-stage B operand
CEI_CEHOLD  out  1  hold CE pipeline (non-CE stall)
CEI_XCPN_M  out  1  exception kill to CE
CEI_RES_M_R  out  32  captured CE result, M stage
CEI_RES_VLD_M_R  out  1  CEI_RES_M_R valid
CEI_STALL  out  1  stall request to core pipeline
CEI_HALT_MISMATCH  out  1  replicated halt bits disagree
CEI_HALT_CNT  out  HCNT_W  saturating count of CE-halt cycles

Behaviour:
- Reset (async, RESET_D1_R_N low): all registered outputs to 0, except CEI_OP_S_R = NOP_OP. FSM goes to RUN.
- Advance = ~CEI_STALL.
- halt_any = OR of CE_HALT_E_R_C.
- CEI_HALT_MISMATCH = halt_any & ~AND of CE_HALT_E_R_C. It is combinational, and halt_any governs behaviour.
- CEI_STALL = PIPE_HOLD | halt_any. Combinational.
- CEI_CEHOLD = PIPE_HOLD registered? No, combinational passthrough: CEI_CEHOLD = PIPE_HOLD. The CE adds its own halt internally.
- CEI_XCPN_M = XCPN_M, combinational.
- On Advance, the S register loads DEC_VALID_S ? DEC_OP_S : NOP_OP. CEI_INSTM32_S_R_N loads DEC_INSTM32_S_N, or 0 when the slot is empty.
- On Advance, the E operand registers load RF_AOP_D / RF_BOP_D. Latency from decode to E operands is 1 cycle after the S op.
- When not advancing, all S and E registers hold.
- XCPN_M on any cycle: S reg loads NOP_OP and operands load 0 at the next edge, regardless of stall. This flushes the pipeline.
- Result capture, on an Advance edge:
  - If CE_SEL_E_R: CEI_RES_M_R <= CE_RES_E and CEI_RES_VLD_M_R <= 1.
  - Otherwise: CEI_RES_VLD_M_R <= 0 and CEI_RES_M_R holds.
  - While stalled, both hold.
  - XCPN_M clears CEI_RES_VLD_M_R at the next edge.
- FSM states: RUN, CEHALT, HOLD.
  - From RUN: halt_any goes to CEHALT; otherwise PIPE_HOLD goes to HOLD; otherwise stay in RUN.
  - From CEHALT: ~halt_any goes to HOLD if PIPE_HOLD, else to RUN.
  - From HOLD: halt_any goes to CEHALT; otherwise ~PIPE_HOLD goes to RUN.
  - XCPN_M forces RUN at the next edge.
  - Halt has priority when halt and hold are simultaneous.
- CEI_HALT_CNT increments on each cycle the state is CEHALT and saturates at all-ones. It is cleared only by reset.
- Reset asserted mid-stall: all registers clear immediately, no residual stall. CEI_STALL then follows only the inputs.

Decomposition:
- Shared package/include: CEI opcode field ranges, M32/M16 major-opcode constants, NOP_OP, HALT_DRV_COUNT, FSM state encoding (RUN=2'b00, CEHALT=2'b01, HOLD=2'b10).
- One sub-module: ce_cei_haltmon, containing the halt OR/AND reduction, mismatch flag, FSM and saturating counter.
- Pipeline registers stay in the top module.

Test Plan:
- Reset release, DEC_VALID_S=1, DEC_OP_S=12'h010 (MFHI), RF_AOP_D=32'h1234_5678 -> next edge CEI_OP_S_R=12'h010; following edge CEI_AOP_E_R=32'h1234_5678.
- CE_SEL_E_R=1, CE_RES_E=32'hDEAD_BEEF, no stall -> next edge CEI_RES_M_R=32'hDEAD_BEEF, CEI_RES_VLD_M_R=1.
- CE_HALT_E_R_C=4'hF for 3 cycles -> CEI_STALL=1 for 3 cycles, S/E registers hold, CEI_HALT_CNT=3, FSM returns to RUN.
- CE_HALT_E_R_C=4'b0101 -> CEI_STALL=1, CEI_HALT_MISMATCH=1.
- PIPE_HOLD=1 and halt together, then halt drops -> FSM CEHALT->HOLD->RUN, CEI_CEHOLD tracks PIPE_HOLD.
- XCPN_M pulse during a halt -> next edge CEI_OP_S_R=NOP_OP, CEI_RES_VLD_M_R=0, FSM=RUN; CEI_HALT_CNT saturates at 8'hFF after 300 halt cycles.
